// File: rtl/teeter_layout_pkg.sv
// rtl/teeter_layout_pkg.sv - shared constants, types and layout table for the level loader
//
// Purpose: geometry constants, coordinate/object types, FSM state encoding,
//          mirror helper and the per-level object layout table used by
//          level_pos_rom and level_pos_loader.
// Ports:   none (package).
package teeter_layout_pkg;

  localparam int NUM_LEVELS = 10;
  localparam int NUM_OBJ    = 9;
  localparam int COORD_W    = 10;
  localparam int LVL_W      = 4;
  localparam int X_MAX      = 288;
  localparam int Y_MAX      = 148;

  localparam int OBJ_BALL   = 0;
  localparam int OBJ_FINISH = 1;

  localparam int IDX_W      = $clog2(NUM_OBJ);
  localparam int ROM_DEPTH  = NUM_LEVELS * NUM_OBJ;
  localparam int ADDR_W     = $clog2(ROM_DEPTH);
  localparam int LIST_W     = 2 * NUM_OBJ * COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // y sits in the upper half so one object packs straight into its pos_list slot
  // (x at the lower COORD_W bits, y at the next COORD_W bits).
  typedef struct packed {
    coord_t y;
    coord_t x;
  } obj_pos_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2
  } ld_state_e;

  function automatic obj_pos_t xy_pos(input int x, input int y);
    obj_pos_t p;
    p.x = coord_t'(x);
    p.y = coord_t'(y);
    return p;
  endfunction

  // Plain modulo-2^COORD_W subtraction: entries above the max wrap, never saturate.
  function automatic obj_pos_t mirror_pos(input obj_pos_t p, input logic mx, input logic my);
    obj_pos_t m;
    m.x = mx ? (coord_t'(X_MAX) - p.x) : p.x;
    m.y = my ? (coord_t'(Y_MAX) - p.y) : p.y;
    return m;
  endfunction

  // Entry level*NUM_OBJ + obj. obj0 = ball start, obj1 = finish hole, rest = holes.
  localparam obj_pos_t LAYOUT [ROM_DEPTH] = '{
    xy_pos(  0,   0), xy_pos(288,   0), xy_pos(144,  74), xy_pos( 40,  30), xy_pos( 80, 110),
    xy_pos(200,  40), xy_pos(240, 120), xy_pos(100,  60), xy_pos(180, 100),
    xy_pos(  0, 148), xy_pos(288,   0), xy_pos(144,  74), xy_pos( 60,  20), xy_pos(120, 130),
    xy_pos(230,  70), xy_pos( 30,  90), xy_pos(260, 140), xy_pos(170,  10),
    xy_pos( 10,  74), xy_pos(278,  74), xy_pos( 72,  37), xy_pos(216,  37), xy_pos( 72, 111),
    xy_pos(216, 111), xy_pos(144,  20), xy_pos(144, 128), xy_pos(144,  74),
    xy_pos(144, 140), xy_pos(144,   8), xy_pos( 20,  20), xy_pos(268,  20), xy_pos( 20, 128),
    xy_pos(268, 128), xy_pos(100,  74), xy_pos(188,  74), xy_pos(144,  40),
    xy_pos(  5,   5), xy_pos(283, 143), xy_pos( 50,  50), xy_pos(100, 100), xy_pos(150,  50),
    xy_pos(200, 100), xy_pos(250,  50), xy_pos( 50, 120), xy_pos(250, 120),
    xy_pos(280,  10), xy_pos(  8, 138), xy_pos( 36,  18), xy_pos( 72,  36), xy_pos(108,  54),
    xy_pos(144,  72), xy_pos(180,  90), xy_pos(216, 108), xy_pos(252, 126),
    xy_pos(144,  74), xy_pos(  0,   0), xy_pos(288, 148), xy_pos(  0, 148), xy_pos(288,   0),
    xy_pos( 72,  74), xy_pos(216,  74), xy_pos(144,  18), xy_pos(144, 130),
    xy_pos( 30, 130), xy_pos(258,  18), xy_pos( 90,  18), xy_pos(150, 130), xy_pos(210,  18),
    xy_pos( 60,  74), xy_pos(120,  74), xy_pos(180,  74), xy_pos(240,  74),
    xy_pos( 12,  12), xy_pos(276, 136), xy_pos( 24, 100), xy_pos( 48,  80), xy_pos( 96,  60),
    xy_pos(144,  40), xy_pos(192,  20), xy_pos(240, 110), xy_pos(264,  60),
    xy_pos(200, 148), xy_pos( 88,   0), xy_pos( 11,  22), xy_pos( 33,  44), xy_pos( 55,  66),
    xy_pos( 77,  88), xy_pos( 99, 110), xy_pos(121, 132), xy_pos(143, 144)
  };

endpackage

// File: rtl/level_pos_rom.sv
// rtl/level_pos_rom.sv - synchronous-read layout ROM over the package table
//
// Purpose: returns the {x,y} entry for i_addr one clock after the address.
//          Data register has no reset (ROM-style).
// Ports:   i_clk  - clock
//          i_addr - level*NUM_OBJ + object index
//          o_data - registered object position
module level_pos_rom
  import teeter_layout_pkg::*;
(
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  output obj_pos_t          o_data
);

  always_ff @(posedge i_clk) begin
    // Addresses past the table read as zero instead of undefined.
    if (i_addr < ADDR_W'(ROM_DEPTH)) begin
      o_data <= LAYOUT[i_addr];
    end else begin
      o_data <= '0;
    end
  end

endmodule

// File: rtl/level_pos_loader.sv
// rtl/level_pos_loader.sv - sequential per-level position loader with atomic commit
//
// Purpose: on load_req in IDLE, streams one object per clock from the layout
//          ROM, optionally mirrors it, stages it and commits the whole list to
//          pos_list in a single edge. Invalid levels are rejected with level_err.
// Ports:   clk, rst_n        - clock, async active-low reset
//          load_req          - load request (sampled in IDLE only)
//          level             - level to load (sampled with load_req)
//          mirror_x/mirror_y - mirror flags (sampled with load_req)
//          busy              - load in progress
//          done              - 1-cycle pulse after commit
//          level_err         - 1-cycle pulse after a rejected request
//          pos_list          - committed object list, obj i x/y at slot i
module level_pos_loader
  import teeter_layout_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [LVL_W-1:0]  level,
  input  logic              mirror_x,
  input  logic              mirror_y,
  output logic              busy,
  output logic              done,
  output logic              level_err,
  output logic [LIST_W-1:0] pos_list
);

  ld_state_e          r_state;
  ld_state_e          w_next_state;

  logic [LVL_W-1:0]   r_level;
  logic               r_mx;
  logic               r_my;
  logic [IDX_W-1:0]   r_idx;

  // Tracks which object the ROM output currently holds (one cycle behind r_idx).
  logic               r_rd_valid;
  logic [IDX_W-1:0]   r_rd_idx;

  obj_pos_t           r_stage [NUM_OBJ];

  logic               w_lvl_ok;
  logic               w_accept;
  logic               w_reject;
  logic               w_commit;
  logic [ADDR_W-1:0]  w_addr;
  obj_pos_t           w_rom_q;
  obj_pos_t           w_obj_m;
  logic [LIST_W-1:0]  w_commit_list;

  assign w_lvl_ok = (level < LVL_W'(NUM_LEVELS));
  assign w_addr   = ADDR_W'(r_level) * ADDR_W'(NUM_OBJ) + ADDR_W'(r_idx);
  assign w_obj_m  = mirror_pos(w_rom_q, r_mx, r_my);

  level_pos_rom u_rom (
    .i_clk  (clk),
    .i_addr (w_addr),
    .o_data (w_rom_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_req && w_lvl_ok) begin
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (r_idx == IDX_W'(NUM_OBJ - 1)) begin
          w_next_state = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = (r_state != ST_IDLE);
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = load_req && w_lvl_ok;
        w_reject = load_req && !w_lvl_ok;
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The last object is still on the ROM output during COMMIT, so it bypasses
  // the staging array and merges directly into the committed list.
  always_comb begin
    w_commit_list = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (r_rd_valid && (r_rd_idx == IDX_W'(i))) begin
        w_commit_list[i*2*COORD_W +: 2*COORD_W] = w_obj_m;
      end else begin
        w_commit_list[i*2*COORD_W +: 2*COORD_W] = r_stage[i];
      end
    end
  end

  // Request latch, index counter, staging and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level    <= '0;
      r_mx       <= 1'b0;
      r_my       <= 1'b0;
      r_idx      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_idx   <= '0;
      done       <= 1'b0;
      level_err  <= 1'b0;
      pos_list   <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_level <= level;
        r_mx    <= mirror_x;
        r_my    <= mirror_y;
        r_idx   <= '0;
      end else if (r_state == ST_FETCH) begin
        r_idx <= r_idx + 1'b1;
      end

      r_rd_valid <= (r_state == ST_FETCH);
      r_rd_idx   <= r_idx;

      if (r_rd_valid) begin
        r_stage[r_rd_idx] <= w_obj_m;
      end

      if (w_commit) begin
        pos_list <= w_commit_list;
      end

      done      <= w_commit;
      level_err <= w_reject;
    end
  end

endmodule

// File: tb/tb_level_pos_loader.sv
// tb/tb_level_pos_loader.sv - randomized self-checking bench for level_pos_loader
module tb_level_pos_loader;
  import teeter_layout_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_req;
  logic [LVL_W-1:0]  level;
  logic              mirror_x;
  logic              mirror_y;
  logic              busy;
  logic              done;
  logic              level_err;
  logic [LIST_W-1:0] pos_list;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [LIST_W-1:0] exp_list;

  always #5 clk = ~clk;

  level_pos_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (load_req),
    .level     (level),
    .mirror_x  (mirror_x),
    .mirror_y  (mirror_y),
    .busy      (busy),
    .done      (done),
    .level_err (level_err),
    .pos_list  (pos_list)
  );

  task automatic chk(input string tag, input logic [LIST_W-1:0] obs, input logic [LIST_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mirror_int(input int v, input int m);
    return ((m - v) % (1 << COORD_W) + (1 << COORD_W)) % (1 << COORD_W);
  endfunction

  // Whole committed list for a level, straight from the layout rules.
  function automatic logic [LIST_W-1:0] model(input int lvl, input int mx, input int my);
    logic [LIST_W-1:0] r;
    int x;
    int y;
    r = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      x = int'(LAYOUT[lvl*NUM_OBJ + i].x);
      y = int'(LAYOUT[lvl*NUM_OBJ + i].y);
      if (mx != 0) x = mirror_int(x, X_MAX);
      if (my != 0) y = mirror_int(y, Y_MAX);
      r[(2*i)*COORD_W +: COORD_W]   = COORD_W'(x);
      r[(2*i+1)*COORD_W +: COORD_W] = COORD_W'(y);
    end
    return r;
  endfunction

  task automatic spot(input string tag, input int obj, input int ex, input int ey);
    chk({tag, "_x"}, LIST_W'(pos_list[(2*obj)*COORD_W +: COORD_W]), LIST_W'(ex));
    chk({tag, "_y"}, LIST_W'(pos_list[(2*obj+1)*COORD_W +: COORD_W]), LIST_W'(ey));
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_load(input int lvl, input int mx, input int my, input int inj_cycle);
    int busy_cycles;
    bit got_done;
    logic [LIST_W-1:0] old;
    old = exp_list;
    load_req = 1'b1;
    level    = LVL_W'(lvl);
    mirror_x = (mx != 0);
    mirror_y = (my != 0);
    @(negedge clk);
    load_req = 1'b0;
    level    = LVL_W'($urandom_range(0, 15));
    mirror_x = 1'($urandom_range(0, 1));
    mirror_y = 1'($urandom_range(0, 1));
    busy_cycles = 0;
    got_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      chk("pos_hold", pos_list, old);
      chk("flags_busy", LIST_W'({done, level_err}), LIST_W'(0));
      load_req = (c == inj_cycle);
      if (c == inj_cycle) level = LVL_W'($urandom_range(0, NUM_LEVELS - 1));
      @(negedge clk);
    end
    load_req = 1'b0;
    chk("done_seen", LIST_W'(got_done), LIST_W'(1));
    chk("busy_len", LIST_W'(busy_cycles), LIST_W'(NUM_OBJ + 1));
    chk("busy_at_done", LIST_W'(busy), LIST_W'(0));
    chk("err_at_done", LIST_W'(level_err), LIST_W'(0));
    exp_list = model(lvl, mx, my);
    chk("commit", pos_list, exp_list);
  endtask

  task automatic reject(input int lvl);
    load_req = 1'b1;
    level    = LVL_W'(lvl);
    @(negedge clk);
    load_req = 1'b0;
    chk("err_pulse", LIST_W'({busy, done, level_err}), LIST_W'(3'b001));
    @(negedge clk);
    chk("err_end", LIST_W'({busy, done, level_err}), LIST_W'(3'b000));
    chk("err_pos", pos_list, exp_list);
  endtask

  initial begin
    rst_n    = 1'b0;
    load_req = 1'b0;
    level    = '0;
    mirror_x = 1'b0;
    mirror_y = 1'b0;
    exp_list = '0;
    repeat (2) @(negedge clk);
    chk("rst_flags", LIST_W'({busy, done, level_err}), LIST_W'(0));
    chk("rst_pos", pos_list, LIST_W'(0));
    rst_n = 1'b1;

    // Idle after reset: nothing moves
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_flags", LIST_W'({busy, done, level_err}), LIST_W'(0));
      chk("idle_pos", pos_list, LIST_W'(0));
    end

    // Plain load of level 0
    run_load(0, 0, 0, 0);
    spot("l0_ball", OBJ_BALL, 0, 0);
    spot("l0_fin", OBJ_FINISH, 288, 0);
    spot("l0_h2", 2, 144, 74);
    @(negedge clk);
    chk("done_1cyc", LIST_W'(done), LIST_W'(0));

    // Mirrored level 0, then level 1
    run_load(0, 1, 1, 0);
    spot("l0m_ball", OBJ_BALL, 288, 148);
    spot("l0m_fin", OBJ_FINISH, 0, 148);
    spot("l0m_h2", 2, 144, 74);
    @(negedge clk);
    run_load(1, 0, 0, 0);
    spot("l1_ball", OBJ_BALL, 0, 148);
    spot("l1_fin", OBJ_FINISH, 288, 0);
    @(negedge clk);

    // Out-of-range levels
    reject(10);
    reject(15);

    // Request while busy is ignored; request in first idle cycle is taken
    run_load(0, 0, 0, 4);
    spot("ign_ball", OBJ_FINISH, 288, 0);
    run_load(2, 1, 0, 0);
    @(negedge clk);

    // Reset in the middle of a level-1 load
    load_req = 1'b1;
    level    = LVL_W'(1);
    @(negedge clk);
    load_req = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pos", pos_list, LIST_W'(0));
    chk("midrst_busy", LIST_W'(busy), LIST_W'(0));
    exp_list = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst_nodone", LIST_W'({busy, done, level_err}), LIST_W'(0));
    end
    run_load(1, 0, 0, 0);
    @(negedge clk);

    // Randomized loads and rejects with random busy-time noise
    for (int n = 0; n < 30; n++) begin
      int lvl;
      lvl = int'($urandom_range(0, 15));
      if (lvl < NUM_LEVELS) begin
        run_load(lvl, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, NUM_OBJ + 1)));
      end else begin
        reject(lvl);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
